// File: rtl/cpu_jmp_unit_if.sv
// cpu_jmp_unit_if: decoder-to-jump-unit bus.
// master (decoder/bench) drives PC_IN, JMP_EN, JMP_MODE, CALL, OFFSET, BASE_SEL, BASE_REG_LD, BASE_REG_DATA;
// slave (cpu_jmp_unit) drives ADDRESS_OUT, JUMP_TAKEN, STACK_EMPTY, STACK_FULL, STACK_ERR.
interface cpu_jmp_unit_if #(
  parameter int WIDTH    = 8,
  parameter int NUM_BASE = 4
);
  logic [WIDTH-1:0]            PC_IN;
  logic                        JMP_EN;
  logic [1:0]                  JMP_MODE;
  logic                        CALL;
  logic [WIDTH-1:0]            OFFSET;
  logic [$clog2(NUM_BASE)-1:0] BASE_SEL;
  logic                        BASE_REG_LD;
  logic [WIDTH-1:0]            BASE_REG_DATA;
  logic [WIDTH-1:0]            ADDRESS_OUT;
  logic                        JUMP_TAKEN;
  logic                        STACK_EMPTY;
  logic                        STACK_FULL;
  logic                        STACK_ERR;
  modport master (
    output PC_IN, JMP_EN, JMP_MODE, CALL, OFFSET, BASE_SEL, BASE_REG_LD, BASE_REG_DATA,
    input  ADDRESS_OUT, JUMP_TAKEN, STACK_EMPTY, STACK_FULL, STACK_ERR
  );
  modport slave (
    input  PC_IN, JMP_EN, JMP_MODE, CALL, OFFSET, BASE_SEL, BASE_REG_LD, BASE_REG_DATA,
    output ADDRESS_OUT, JUMP_TAKEN, STACK_EMPTY, STACK_FULL, STACK_ERR
  );
endinterface

// File: rtl/cpu_jmp_unit.sv
// cpu_jmp_unit: next-PC generator with a base-register bank and a return-address stack.
// Ports: CLK, RST (sync, active-high), bus (cpu_jmp_unit_if.slave) carrying PC/jump/call/base-load
// inputs and ADDRESS_OUT, JUMP_TAKEN, STACK_EMPTY, STACK_FULL, STACK_ERR outputs.
// Define CPU_JMP_BASE_BYPASS_EN to forward a same-cycle base load into the mode-01 target.
module cpu_jmp_unit #(
  parameter int WIDTH       = 8,
  parameter int NUM_BASE    = 4,
  parameter int STACK_DEPTH = 4
) (
  input logic           CLK,
  input logic           RST,
  cpu_jmp_unit_if.slave bus
);
  localparam int SW = $clog2(STACK_DEPTH + 1);
  localparam int IW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  logic [WIDTH-1:0] base_q [NUM_BASE];
  logic [WIDTH-1:0] base_d [NUM_BASE];
  logic [WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [WIDTH-1:0] stack_d [STACK_DEPTH];
  logic [SW-1:0]    sp_q, sp_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] fall, base_val, target;
  logic [IW-1:0]    top_idx, push_idx;
  logic             do_call, do_ret, empty, full, taken;
  always_comb begin
    fall     = bus.PC_IN + 1'b1;
    empty    = sp_q == '0;
    full     = sp_q == SW'(STACK_DEPTH);
    do_call  = bus.JMP_EN && bus.CALL && bus.JMP_MODE != 2'b11;
    do_ret   = bus.JMP_EN && bus.JMP_MODE == 2'b11;
    top_idx  = IW'(sp_q - 1'b1);
    push_idx = IW'(sp_q);
`ifdef CPU_JMP_BASE_BYPASS_EN
    base_val = bus.BASE_REG_LD ? bus.BASE_REG_DATA : base_q[bus.BASE_SEL];
`else
    base_val = base_q[bus.BASE_SEL];
`endif
    // Mode 10: a WIDTH-bit add already equals PC + sign-extended offset mod 2^WIDTH
    target = bus.JMP_MODE == 2'b00 ? bus.OFFSET :
             bus.JMP_MODE == 2'b01 ? base_val + bus.OFFSET :
             bus.JMP_MODE == 2'b10 ? bus.PC_IN + bus.OFFSET : stack_q[top_idx];
    // Overflowing call or underflowing return falls through instead of jumping
    taken = bus.JMP_EN && (do_ret ? !empty : !(do_call && full));
    base_d  = base_q;
    stack_d = stack_q;
    sp_d    = sp_q;
    err_d   = err_q || (do_call && full) || (do_ret && empty);
    if (bus.BASE_REG_LD) base_d[bus.BASE_SEL] = bus.BASE_REG_DATA;
    if (do_call && !full) begin
      stack_d[push_idx] = fall;
      sp_d = sp_q + 1'b1;
    end
    if (do_ret && !empty) sp_d = sp_q - 1'b1;
  end
  assign bus.ADDRESS_OUT = taken ? target : fall;
  assign bus.JUMP_TAKEN  = taken;
  assign bus.STACK_EMPTY = empty;
  assign bus.STACK_FULL  = full;
  assign bus.STACK_ERR   = err_q;
  // Stack entries are unreset; clearing SP is enough to discard them
  always_ff @(posedge CLK) begin
    if (RST) begin
      base_q <= '{default: '0};
      sp_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      base_q <= base_d;
      sp_q   <= sp_d;
      err_q  <= err_d;
    end
    stack_q <= stack_d;
  end
endmodule
